mem_ingress_pipe: RTL

MEM_INGRESS_PIPE -- requirements
Module: mem_ingress_pipe

---
 rtl/mem_ingress_pipe.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_ingress_pipe.sv
// Ingress pipeline in front of a credit-tracked memory: one stage register
// feeding the write port plus one skid register, with write pointer and level.
module mem_ingress_pipe #(
    parameter int W = 32,
    parameter int N = 16,
    localparam int ADDR_BITS = $clog2(N),
    localparam int PTR_BITS  = ADDR_BITS + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 in_ready_r,
    input  logic                 rel,
    output logic                 mem_wen,
    output logic [ADDR_BITS-1:0] mem_waddr,
    output logic [W-1:0]         mem_wdata,
    output logic [PTR_BITS-1:0]  wptr_r,
    output logic [PTR_BITS-1:0]  level_r,
    output logic                 full_r
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SKID = 2'd2
    } state_t;

    localparam logic [PTR_BITS-1:0] FULL_LVL = PTR_BITS'(N);

    state_t              state_q, state_d;
    logic [W-1:0]        s0_q, s0_d;
    logic [W-1:0]        s1_q, s1_d;
    logic [PTR_BITS-1:0] wptr_q, wptr_d;
    logic [PTR_BITS-1:0] level_q, level_d;
    logic                full_q, full_d;
    logic                in_ready_s;
    logic                busy_s;
    logic                accept_s;
    logic                write_s;

    // Output decode: ready and "holding data" come from the state flops only.
    always_comb begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            HOLD: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            SKID: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
            end
            default: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    assign accept_s   = in_valid & in_ready_s;
    assign write_s    = busy_s & (level_q != FULL_LVL);

    assign in_ready_r = in_ready_s;
    assign mem_wen    = write_s;
    assign mem_waddr  = wptr_q[ADDR_BITS-1:0];
    assign mem_wdata  = s0_q;
    assign wptr_r     = wptr_q;
    assign level_r    = level_q;
    assign full_r     = full_q;

    // Next-state and data-register steering for the stage/skid pair.
    always_comb begin
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = HOLD;
                    s0_d    = in_data;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (write_s && accept_s) begin
                    state_d = HOLD;
                    s0_d    = in_data;
                end else if (write_s) begin
                    state_d = IDLE;
                end else if (accept_s) begin
                    state_d = SKID;
                    s1_d    = in_data;
                end else begin
                    state_d = HOLD;
                end
            end
            SKID: begin
                if (write_s) begin
                    state_d = HOLD;
                    s0_d    = s1_q;
                end else begin
                    state_d = SKID;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer and occupancy bookkeeping; a release at level 0 is dropped.
    always_comb begin
        wptr_d  = write_s ? (wptr_q + PTR_BITS'(1)) : wptr_q;
        level_d = level_q;
        case ({write_s, rel})
            2'b10: level_d = level_q + PTR_BITS'(1);
            2'b01: begin
                if (level_q != {PTR_BITS{1'b0}}) begin
                    level_d = level_q - PTR_BITS'(1);
                end else begin
                    level_d = level_q;
                end
            end
            default: level_d = level_q;
        endcase
        full_d = (level_d == FULL_LVL);
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wptr_q  <= {PTR_BITS{1'b0}};
            level_q <= {PTR_BITS{1'b0}};
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            full_q  <= full_d;
        end
    end

    // Datapath registers carry no reset; their contents only matter once loaded.
    always_ff @(posedge clk) begin
        s0_q <= s0_d;
        s1_q <= s1_d;
    end

endmodule
